// File: rtl/dff_debounce_edge.sv
// Debounces a registered single-bit level, emits rise/fall pulses and counts qualified rises.
// Build option: define EDGE_CNT_SAT_EN to make edge_count saturate instead of wrap.
`timescale 1ns/1ps

// state   | meaning
// IDLE    | d_r agrees with q, nothing pending
// QUALIFY | d_r differs from q, stab_cnt counts consecutive differing samples
module dff_debounce_edge #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                 clk,
  input  logic                 sync_reset,
  input  logic                 d,
  input  logic                 clr_count,
  output logic                 q,
  output logic                 rise,
  output logic                 fall,
  output logic [CNT_WIDTH-1:0] edge_count,
  output logic                 busy
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam logic [SW-1:0] LAST = SW'(STABLE_CYCLES - 1);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] QUALIFY = 1'b1;

  logic                 d_r;
  logic [SW-1:0]        stab_cnt;
  logic [0:0]           state;
  logic                 differ;
  logic                 update;
  logic [CNT_WIDTH-1:0] next_count;

  assign differ = (d_r != q);
  // With a single required sample the change is taken straight from IDLE.
  assign update = differ &&
                  ((STABLE_CYCLES == 1) || ((state == QUALIFY) && (stab_cnt == LAST)));
  assign busy   = (state == QUALIFY);

  always_comb begin
`ifdef EDGE_CNT_SAT_EN
    next_count = (&edge_count) ? edge_count : edge_count + CNT_WIDTH'(1);
`else
    next_count = edge_count + CNT_WIDTH'(1);
`endif
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      d_r        <= 1'b0;
      q          <= 1'b0;
      rise       <= 1'b0;
      fall       <= 1'b0;
      edge_count <= '0;
      stab_cnt   <= '0;
      state      <= IDLE;
    end else begin
      d_r  <= d;
      rise <= update && d_r;
      fall <= update && !d_r;
      if (update) begin
        q <= d_r;
      end
      // A clear coinciding with a rise wins; that rise is not counted.
      if (clr_count) begin
        edge_count <= '0;
      end else if (update && d_r) begin
        edge_count <= next_count;
      end
      case (state)
        IDLE: begin
          if (differ && (STABLE_CYCLES > 1)) begin
            state    <= QUALIFY;
            stab_cnt <= SW'(1);
          end else begin
            stab_cnt <= '0;
          end
        end
        QUALIFY: begin
          if (!differ || update) begin
            state    <= IDLE;
            stab_cnt <= '0;
          end else begin
            stab_cnt <= stab_cnt + SW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dff_debounce_edge.sv
// Bench for dff_debounce_edge: directed vector table, hand-written corner sequences and
// a randomized run checked every cycle against a sample-window reference model.
`timescale 1ns/1ps

module tb_dff_debounce_edge;

  localparam int S  = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          sync_reset = 1'b1;
  logic          d = 1'b0;
  logic          clr_count = 1'b0;
  logic          q, rise, fall, busy;
  logic [CW-1:0] edge_count;

  int vectors = 0;
  int miscompares = 0;

  dff_debounce_edge #(.STABLE_CYCLES(S), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .sync_reset (sync_reset),
    .d          (d),
    .clr_count  (clr_count),
    .q          (q),
    .rise       (rise),
    .fall       (fall),
    .edge_count (edge_count),
    .busy       (busy)
  );

  always #10 clk = ~clk;

  // Reference: q flips once the last S samples seen by the filter all differ from q.
  logic          m_dr = 1'b0, m_q = 1'b0, m_rise = 1'b0, m_fall = 1'b0, m_busy = 1'b0;
  logic [CW-1:0] m_cnt = '0;
  logic          hist[$];
  int            m_trail;
  bit            m_all;

  always @(posedge clk) begin
    if (sync_reset) begin
      m_dr = 1'b0; m_q = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_cnt = '0;
      hist.delete();
    end else begin
      hist.push_back(m_dr);
      if (hist.size() > S) void'(hist.pop_front());
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (hist.size() == S) begin
        m_all = 1'b1;
        foreach (hist[i]) if (hist[i] == m_q) m_all = 1'b0;
        if (m_all) begin
          m_q    = ~m_q;
          m_rise = m_q;
          m_fall = ~m_q;
        end
      end
      if (clr_count) m_cnt = '0;
      else if (m_rise) begin
`ifdef EDGE_CNT_SAT_EN
        if (int'(m_cnt) < (1 << CW) - 1) m_cnt = m_cnt + 1'b1;
`else
        m_cnt = CW'((int'(m_cnt) + 1) % (1 << CW));
`endif
      end
      m_dr = d;
    end
    m_trail = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] == m_q) break;
      m_trail++;
    end
    m_busy = (m_trail >= 1) && (m_trail <= S - 1);
  end

  always @(negedge clk) begin
    vectors++;
    if ({q, rise, fall, busy, edge_count} !== {m_q, m_rise, m_fall, m_busy, m_cnt}) begin
      miscompares++;
      $display("FAIL model t=%0t: got q=%b rise=%b fall=%b busy=%b cnt=%0d expected q=%b rise=%b fall=%b busy=%b cnt=%0d",
               $time, q, rise, fall, busy, edge_count, m_q, m_rise, m_fall, m_busy, m_cnt);
    end
    vectors++;
    if (rise && fall) begin
      miscompares++;
      $display("FAIL pulse_excl t=%0t: got rise=1 fall=1 expected not both", $time);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  typedef struct {
    logic rst, din, clr;
    logic eq, erise, efall, ebusy;
    int   ecnt;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mk(logic rst, logic din, logic clr, logic eq, logic er,
                              logic ef, logic eb, int ec);
    vec_t v;
    v.rst = rst; v.din = din; v.clr = clr;
    v.eq = eq; v.erise = er; v.efall = ef; v.ebusy = eb; v.ecnt = ec;
    return v;
  endfunction

  int sat_top;

  initial begin
    // reset hold, deassert with d=1, rise
    tbl[0]  = mk(1, 1, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 1, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 1, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 1, 0, 0, 0, 0, 0, 0);
    tbl[4]  = mk(0, 1, 0, 0, 0, 0, 1, 0);
    tbl[5]  = mk(0, 1, 0, 0, 0, 0, 1, 0);
    tbl[6]  = mk(0, 1, 0, 0, 0, 0, 1, 0);
    tbl[7]  = mk(0, 1, 0, 1, 1, 0, 0, 1);
    tbl[8]  = mk(0, 1, 0, 1, 0, 0, 0, 1);
    // fall path
    tbl[9]  = mk(0, 0, 0, 1, 0, 0, 0, 1);
    tbl[10] = mk(0, 0, 0, 1, 0, 0, 1, 1);
    tbl[11] = mk(0, 0, 0, 1, 0, 0, 1, 1);
    tbl[12] = mk(0, 0, 0, 1, 0, 0, 1, 1);
    tbl[13] = mk(0, 0, 0, 0, 0, 1, 0, 1);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 1);
    // three-cycle glitch is rejected
    tbl[15] = mk(0, 1, 0, 0, 0, 0, 0, 1);
    tbl[16] = mk(0, 1, 0, 0, 0, 0, 1, 1);
    tbl[17] = mk(0, 1, 0, 0, 0, 0, 1, 1);
    tbl[18] = mk(0, 0, 0, 0, 0, 0, 1, 1);
    tbl[19] = mk(0, 0, 0, 0, 0, 0, 0, 1);
    tbl[20] = mk(0, 0, 0, 0, 0, 0, 0, 1);
    tbl[21] = mk(0, 0, 1, 0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      sync_reset = tbl[i].rst;
      d          = tbl[i].din;
      clr_count  = tbl[i].clr;
      tick(1);
      chk($sformatf("tbl%0d_q", i),    q,          tbl[i].eq);
      chk($sformatf("tbl%0d_rise", i), rise,       tbl[i].erise);
      chk($sformatf("tbl%0d_fall", i), fall,       tbl[i].efall);
      chk($sformatf("tbl%0d_busy", i), busy,       tbl[i].ebusy);
      chk($sformatf("tbl%0d_cnt", i),  edge_count, tbl[i].ecnt);
    end
    clr_count = 1'b0;

    // counter boundary: 16 qualified rises
    for (int i = 1; i <= 16; i++) begin
      d = 1'b1;
      tick(6);
      if (i == 15) chk("cnt_after15", edge_count, 15);
`ifdef EDGE_CNT_SAT_EN
      if (i == 16) chk("cnt_after16_sat", edge_count, 15);
`else
      if (i == 16) chk("cnt_after16_wrap", edge_count, 0);
`endif
      d = 1'b0;
      tick(6);
    end

    // clear coincident with the rise
    d = 1'b1;
    tick(6);
`ifdef EDGE_CNT_SAT_EN
    sat_top = 15;
`else
    sat_top = 1;
`endif
    chk("cnt_pre_clr", edge_count, sat_top);
    d = 1'b0;
    tick(6);
    d = 1'b1;
    tick(4);
    clr_count = 1'b1;
    tick(1);
    clr_count = 1'b0;
    chk("clr_rise_pulse", rise, 1);
    chk("clr_rise_cnt", edge_count, 0);
    tick(1);
    chk("clr_rise_one_cycle", rise, 0);
    d = 1'b0;
    tick(6);

    // reset while stab_cnt == 2
    d = 1'b1;
    tick(3);
    chk("midq_busy_before", busy, 1);
    sync_reset = 1'b1;
    tick(1);
    sync_reset = 1'b0;
    chk("midq_busy", busy, 0);
    chk("midq_q", q, 0);
    chk("midq_pulses", {rise, fall}, 0);
    tick(4);
    chk("requal_q_early", q, 0);
    chk("requal_busy", busy, 1);
    tick(1);
    chk("requal_q", q, 1);
    chk("requal_rise", rise, 1);

    // fast toggle: period 46 ns never gives four equal samples
    sync_reset = 1'b1;
    d = 1'b0;
    tick(1);
    sync_reset = 1'b0;
    fork
      begin
        #4.5;
        repeat (130) begin
          #23 d = ~d;
        end
      end
      begin
        for (int i = 0; i < 150; i++) begin
          tick(1);
          if (q !== 1'b0 || rise !== 1'b0 || fall !== 1'b0 || edge_count !== '0) begin
            chk("toggle_quiet", {q, rise, fall, edge_count}, 0);
          end
        end
        chk("toggle_q_end", q, 0);
        chk("toggle_cnt_end", edge_count, 0);
      end
    join
    d = 1'b0;

    // randomized run, checked by the reference every cycle
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 4) == 0) d = ~d;
      clr_count  = ($urandom_range(0, 49) == 0);
      sync_reset = ($urandom_range(0, 149) == 0);
      tick(1);
    end
    sync_reset = 1'b0;
    clr_count  = 1'b0;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dff_debounce_edge.md
Name: dff_debounce_edge

Overview:
- Downstream consumer of a single-bit registered flop output (`q` of the team's `dff_*` cells).
- Filters the bit with a stability counter and drives a debounced level.
- Generates single-cycle rise/fall pulses and counts qualified rising edges.
- Sits between the raw flop stage and any logic that needs a clean, event-counted level.

Parameters:
- STABLE_CYCLES, 4: consecutive mismatching samples required before `q` changes; legal range >= 1.
- CNT_WIDTH, 8: width of `edge_count`; legal range >= 1.

Ports:
- clk  input  1  rising-edge clock.
- sync_reset  input  1  synchronous reset, active-high.
- d  input  1  raw bit from the upstream flop; synchronous to `clk`.
- clr_count  input  1  synchronous clear of `edge_count`.
- q  output  1  debounced level.
- rise  output  1  one-cycle pulse, `q` went 0->1.
- fall  output  1  one-cycle pulse, `q` went 1->0.
- edge_count  output  CNT_WIDTH  number of qualified rising edges.
- busy  output  1  high while a candidate change is being qualified.

Behaviour:
- Interface (already decided): one clock `clk`; reset `sync_reset` is synchronous and active-high.
- Reset:
  - `sync_reset` has priority over all other logic, including `clr_count`.
  - Reset values: `q`=0, `rise`=0, `fall`=0, `edge_count`=0, `busy`=0.
  - Internal reset values: `d_r`=0, stab_cnt=0, state=IDLE.
- Input register: `d_r` <= `d` every cycle when not in reset.
- stab_cnt width: clog2(STABLE_CYCLES+1).
- State machine:
  - IDLE, `d_r`==`q`: stay in IDLE, stab_cnt=0.
  - IDLE, `d_r`!=`q`, STABLE_CYCLES==1: `q` <= `d_r` on this edge; stay in IDLE.
  - IDLE, `d_r`!=`q`, STABLE_CYCLES>1: go to QUALIFY, stab_cnt <= 1.
  - QUALIFY, `d_r`==`q`: glitch; abort to IDLE, stab_cnt <= 0, `q` unchanged, no pulse.
  - QUALIFY, `d_r`!=`q` and stab_cnt==STABLE_CYCLES-1: update; `q` <= `d_r`, stab_cnt <= 0, go to IDLE.
  - QUALIFY, `d_r`!=`q` otherwise: stab_cnt <= stab_cnt+1.
- Latency:
  - Edge k is the first edge at which `d_r` captures the new value.
  - `q` changes at edge k+STABLE_CYCLES.
  - From a change on `d`, `q` changes STABLE_CYCLES+1 edges later.
- Pulses:
  - `rise`/`fall` are registered and asserted in the same cycle `q` takes its new value.
  - Each lasts exactly one cycle.
  - Never both high in the same cycle.
  - Never asserted out of reset or on an abort.
- `busy`: combinational decode of state==QUALIFY.
- edge_count:
  - Increments by 1 on the edge that sets `rise`.
  - `clr_count` has priority over the increment: a coincident clear gives 0, and that rising edge is lost.
  - On overflow, all-ones +1 wraps to 0 (see Optional Feature).
- Reset mid-QUALIFY: the candidate is discarded; the next cycle shows all reset values and no pulse.
- An input toggling faster than STABLE_CYCLES samples never changes `q`.

Optional Feature:
- Macro: EDGE_CNT_SAT_EN.
- Defined: `edge_count` saturates at 2^CNT_WIDTH-1; further rises leave it unchanged. `clr_count` still clears it to 0.
- Undefined: `edge_count` wraps modulo 2^CNT_WIDTH.
- `q`, `rise`, `fall` and `busy` are identical in both builds.

Test Plan:
- Reset hold, STABLE_CYCLES=4:
  - `sync_reset`=1 for 3 cycles with `d`=1 -> `q`=0, `rise`=0, `edge_count`=0, `busy`=0 throughout.
  - Deassert with `d` held 1 -> `d_r`=1 at first edge, `q`=1 and `rise`=1 for one cycle at 4th edge after, `edge_count`=1.
- Glitch reject, STABLE_CYCLES=4, from `q`=0:
  - `d`=1 for exactly 3 cycles, then 0 -> `busy` high 3 cycles, `q` stays 0, `rise` never asserted, `edge_count` unchanged.
- Fast toggle, STABLE_CYCLES=4:
  - 20 ns clk period, `d` inverted every 23 ns for 3000 ns -> `q` constant 0, no pulses, `edge_count`=0.
- Fall path:
  - From `q`=1, `d`=0 held -> `q`=0 and `fall`=1 for one cycle STABLE_CYCLES edges after `d_r` falls; `edge_count` unchanged.
- Counter boundary, CNT_WIDTH=4:
  - 16 qualified rising edges -> `edge_count` reads 15 after the 15th and 0 after the 16th (macro undefined), 15 after the 16th (EDGE_CNT_SAT_EN defined).
  - `clr_count`=1 in the `rise` cycle -> `edge_count`=0.
- Reset mid-qualify:
  - `sync_reset`=1 while stab_cnt=2 in QUALIFY -> next edge `busy`=0, `q` at reset value, no `rise`/`fall`.
  - Requalification restarts from stab_cnt=0 after release.
